// File: rtl/keypad_encoder_pkg.sv
// Shared constants and enumerations for the keypad encoder.
// Key codes 0-15 are hex digits; W and NONE are reserved.
package keypad_encoder_pkg;

  localparam logic [4:0] KEY_W    = 5'd16;
  localparam logic [4:0] KEY_NONE = 5'd31;

  typedef enum logic [1:0] {
    IDLE,
    DEBOUNCE,
    EMIT,
    RELEASE
  } enc_state_t;

  typedef enum logic [1:0] {
    CLS_NONE,
    CLS_SINGLE,
    CLS_MULTI
  } frame_cls_t;

endpackage

// File: rtl/keypad_encoder_sync2.sv
// Parameterized-width two-flop synchronizer.
// Reset clears both stages.
module sync2 #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_encoder.sv
// 4x4 keypad scanner plus W button with frame debounce.
// Emits one strobe per qualified press.
module keypad_encoder
  import keypad_encoder_pkg::*;
#(
  parameter int SCAN_DIV        = 1000,
  parameter int DEBOUNCE_FRAMES = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] col_n,
  input  logic       w_btn,
  output logic [3:0] row_n,
  output logic [4:0] keyout,
  output logic       strobe
);

  localparam int SW = $clog2(SCAN_DIV);
  localparam int FW = $clog2(DEBOUNCE_FRAMES + 1);
  localparam logic [FW-1:0] DF = FW'(DEBOUNCE_FRAMES);

  logic [4:0]    hits;
  logic [SW-1:0] scan_cnt;
  logic [1:0]    row;
  logic [1:0]    acc_cnt;
  logic [4:0]    acc_code;
  logic          sample;
  logic          frame_done;
  logic [4:0]    row_hits;
  logic [2:0]    row_cnt;
  logic [4:0]    row_code;
  logic [2:0]    tot;
  logic [4:0]    fcode;
  frame_cls_t    cls;

  enc_state_t    state, state_d;
  logic [FW-1:0] frame_cnt, cnt_d, cnt_inc;
  logic [4:0]    code, code_d;

  // Columns inverted first so a cleared synchronizer reads as no key.
  sync2 #(.W(5)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     ({w_btn, ~col_n}),
    .q     (hits)
  );

  assign sample     = scan_cnt == SW'(SCAN_DIV - 1);
  assign frame_done = sample && row == 2'd3;
  assign row_n      = ~(4'b0001 << row);

  always_comb begin
    row_hits = {hits[4] && row == 2'd3, hits[3:0]};
    row_cnt  = '0;
    for (int i = 0; i < 5; i++)
      row_cnt = row_cnt + {2'b00, row_hits[i]};
    row_code = KEY_W;
    for (int c = 3; c >= 0; c--)
      if (row_hits[c])
        row_code = {1'b0, row, 2'(c)};
  end

  assign tot   = {1'b0, acc_cnt} + row_cnt;
  assign fcode = (acc_cnt != 2'd0) ? acc_code : row_code;

  always_comb begin
    cls = CLS_MULTI;
    if (tot == 3'd0)
      cls = CLS_NONE;
    else if (tot == 3'd1)
      cls = CLS_SINGLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt <= '0;
      row      <= 2'd0;
      acc_cnt  <= 2'd0;
      acc_code <= KEY_NONE;
    end else if (sample) begin
      scan_cnt <= '0;
      row      <= row + 2'd1;
      if (row == 2'd3) begin
        acc_cnt  <= 2'd0;
        acc_code <= KEY_NONE;
      end else begin
        acc_cnt  <= (tot >= 3'd2) ? 2'd2 : tot[1:0];
        acc_code <= fcode;
      end
    end else begin
      scan_cnt <= scan_cnt + SW'(1);
    end
  end

  assign cnt_inc = (frame_cnt == DF) ? frame_cnt
                                     : frame_cnt + FW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      frame_cnt <= '0;
      code      <= KEY_NONE;
    end else begin
      state     <= state_d;
      frame_cnt <= cnt_d;
      code      <= code_d;
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = frame_cnt;
    code_d  = code;
    strobe  = 1'b0;
    keyout  = KEY_NONE;
    unique case (state)
      IDLE: begin
        if (frame_done && cls == CLS_SINGLE) begin
          code_d  = fcode;
          cnt_d   = FW'(1);
          state_d = DEBOUNCE;
        end
      end
      DEBOUNCE: begin
        if (frame_done) begin
          if (cls == CLS_SINGLE && fcode == code) begin
            cnt_d = cnt_inc;
            if (cnt_inc == DF)
              state_d = EMIT;
          end else begin
            cnt_d   = '0;
            state_d = IDLE;
          end
        end
      end
      EMIT: begin
        strobe  = 1'b1;
        keyout  = code;
        cnt_d   = '0;
        state_d = RELEASE;
      end
      RELEASE: begin
        if (frame_done) begin
          if (cls == CLS_NONE) begin
            cnt_d = cnt_inc;
            if (cnt_inc == DF) begin
              cnt_d   = '0;
              state_d = IDLE;
            end
          end else begin
            cnt_d = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: doc/keypad_encoder.md
KEYPAD_ENCODER -- requirements
Module: keypad_encoder

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 1000: clocks each row is driven before its columns are sampled (minimum 4).
REQ-002 SHALL have parameter DEBOUNCE_FRAMES, default 8: consecutive identical scan frames needed to accept a press or release (minimum 2).
REQ-003 SHALL have port clk  input  1: sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1: reset, asynchronous, active-low.
REQ-005 SHALL have port col_n  input  4: keypad column lines, active-low, asynchronous to clk.
REQ-006 SHALL have port w_btn  input  1: dedicated W (enter) pushbutton, active-high, asynchronous to clk.
REQ-007 SHALL have port row_n  output  4: keypad row drives, exactly one bit low at all times.
REQ-008 SHALL have port keyout  output  5: accepted key code 0-15 (hex digit) or 16 (W); KEY_NONE (31) otherwise.
REQ-009 SHALL have port strobe  output  1: one-cycle pulse marking a valid keyout.

Function
REQ-010 SHALL pass col_n and w_btn through two-flop synchronizers before any use.
REQ-011 SHALL rotate row_n 1110 -> 1101 -> 1011 -> 0111 -> 1110, each row held SCAN_DIV clocks; one full rotation is a frame.
REQ-012 SHALL sample synchronized columns on the last clock of each row slot; column c low while row r is driven means key code 4*r + c.
REQ-013 SHALL sample synchronized w_btn on the same clock as the row-3 column sample; high means code 16.
REQ-014 SHALL classify each frame at its end as NONE (no key), SINGLE(code) (exactly one key, W included) or MULTI (two or more keys).
REQ-015 SHALL implement states IDLE, DEBOUNCE, EMIT, RELEASE.
REQ-016 IDLE: a SINGLE frame latches the code, sets the frame count to 1 and moves to DEBOUNCE; NONE and MULTI frames stay in IDLE.
REQ-017 DEBOUNCE: a SINGLE frame with the latched code increments the count; reaching DEBOUNCE_FRAMES moves to EMIT; any other frame returns to IDLE.
REQ-018 EMIT: lasts exactly one clock, with strobe=1 and keyout equal to the latched code; then moves to RELEASE with the count cleared.
REQ-019 RELEASE: a NONE frame increments the count, reaching DEBOUNCE_FRAMES returns to IDLE; SINGLE or MULTI frames clear the count; no emission occurs in RELEASE.
REQ-020 SHALL hold keyout=31 and strobe=0 on every clock outside EMIT.
REQ-021 SHALL emit exactly one strobe per press regardless of hold duration; a key held through RELEASE never re-emits.
REQ-022 SHALL make a key change or second key during DEBOUNCE restart qualification without emission.
REQ-023 SHALL run the frame scan continuously in every state; press-to-strobe latency is at most DEBOUNCE_FRAMES+1 frames plus 3 clocks.
REQ-024 SHALL saturate all counters and never wrap.

Reset
REQ-025 While rst_n=0: state IDLE, row_n=1110, scan and frame counters 0, keyout=31, strobe=0, synchronizers cleared.
REQ-026 SHALL abandon a pending press on reset mid-DEBOUNCE or mid-RELEASE; after release of reset, a still-held key is qualified afresh from IDLE.

Structure
REQ-027 SHALL place in the shared lock package: KEY_W=5'd16, KEY_NONE=5'd31, and the encoder state enumeration; lock FSM and encoder SHALL share these constants.
REQ-028 SHALL instantiate one sub-module, sync2 (parameterized-width two-flop synchronizer), for col_n and w_btn.

Verification (SCAN_DIV=4, DEBOUNCE_FRAMES=3; frame = 16 clocks)
REQ-029 Reset asserted for 5 clocks and released with no keys -> row_n=1110, keyout=31, strobe=0; row_n rotates every 4 clocks; strobe never pulses.
REQ-030 Key at row 2, col 1 held 10 frames -> exactly one strobe with keyout=9, within 4 frames + 3 clocks of press; keyout=31 otherwise.
REQ-031 w_btn held 6 frames, released 4 frames, then digit 5 held 6 frames -> exactly two strobes: keyout=16, then keyout=5.
REQ-032 Key 3 bouncing (2 frames on, 1 off, repeated), then held solid -> no strobe during bounce; one strobe keyout=3 after 3 solid frames.
REQ-033 Keys 0 and 7 pressed together for 5 frames, then 0 released -> no strobe while both are held; one strobe keyout=7 after 3 frames of 7 alone.
REQ-034 rst_n pulsed low during DEBOUNCE of key 12 (still held) -> no strobe before reset; one strobe keyout=12 three frames after reset release.
